// File: rtl/sap_control_sequencer.sv
// T-state sequencer and microcode decoder for the SAP 8-bit CPU: 3-state fetch, 1-3 state execute, halt, run/freeze.
// Optional conditional jumps (JC/JZ) are enabled by defining SEQ_COND_JUMP_EN.
module sap_control_sequencer #(
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    input  logic [OPW-1:0] ir_opcode,
    input  logic           flag_c,
    input  logic           flag_z,
    output logic           pc_clr_n,
    output logic           cp,
    output logic           ep,
    output logic           lp,
    output logic           lm,
    output logic           ce,
    output logic           li,
    output logic           ei,
    output logic           la,
    output logic           ea,
    output logic           lb,
    output logic           su,
    output logic           eu,
    output logic           lo,
    output logic           halted,
    output logic [2:0]     t_state
);

    typedef enum logic [2:0] {
        S_CLR  = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_T5   = 3'd5,
        S_T6   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    localparam logic [OPW-1:0] OP_LDA = OPW'(4'b0000);
    localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0001);
    localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0010);
    localparam logic [OPW-1:0] OP_JMP = OPW'(4'b0011);
    localparam logic [OPW-1:0] OP_JC  = OPW'(4'b0100);
    localparam logic [OPW-1:0] OP_JZ  = OPW'(4'b0101);
    localparam logic [OPW-1:0] OP_OUT = OPW'(4'b1110);
    localparam logic [OPW-1:0] OP_HLT = OPW'(4'b1111);

    state_t state;
    logic   is_long;

    assign is_long = (ir_opcode == OP_LDA) || (ir_opcode == OP_ADD) || (ir_opcode == OP_SUB);

    // CLR always advances and HALT is sticky; every other state freezes while run is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_CLR;
        end else if (state == S_CLR) begin
            state <= S_T1;
        end else if (state != S_HALT && run) begin
            case (state)
                S_T1:    state <= S_T2;
                S_T2:    state <= S_T3;
                S_T3:    state <= S_T4;
                S_T4: begin
                    if (is_long)
                        state <= S_T5;
                    else if (ir_opcode == OP_HLT)
                        state <= S_HALT;
                    else
                        state <= S_T1;
                end
                S_T5:    state <= S_T6;
                default: state <= S_T1;
            endcase
        end
    end

    // Strobes follow state and opcode directly so the datapath sees them in the same cycle.
    always_comb begin
        cp = 1'b0; ep = 1'b0; lp = 1'b0; lm = 1'b0; ce = 1'b0; li = 1'b0; ei = 1'b0;
        la = 1'b0; ea = 1'b0; lb = 1'b0; su = 1'b0; eu = 1'b0; lo = 1'b0;
        if (run) begin
            case (state)
                S_T1: begin ep = 1'b1; lm = 1'b1; end
                S_T2: cp = 1'b1;
                S_T3: begin ce = 1'b1; li = 1'b1; end
                S_T4: begin
                    case (ir_opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin ei = 1'b1; lm = 1'b1; end
                        OP_JMP:                 begin ei = 1'b1; lp = 1'b1; end
                        OP_OUT:                 begin ea = 1'b1; lo = 1'b1; end
`ifdef SEQ_COND_JUMP_EN
                        OP_JC: begin ei = flag_c; lp = flag_c; end
                        OP_JZ: begin ei = flag_z; lp = flag_z; end
`endif
                        default: ;
                    endcase
                end
                S_T5: begin
                    case (ir_opcode)
                        OP_LDA:         begin ce = 1'b1; la = 1'b1; end
                        OP_ADD, OP_SUB: begin ce = 1'b1; lb = 1'b1; end
                        default: ;
                    endcase
                end
                S_T6: begin
                    case (ir_opcode)
                        OP_ADD: begin eu = 1'b1; la = 1'b1; end
                        OP_SUB: begin su = 1'b1; eu = 1'b1; la = 1'b1; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

`ifndef SEQ_COND_JUMP_EN
    logic flags_unused;
    assign flags_unused = ^{flag_c, flag_z};
`endif

    assign pc_clr_n = (state != S_CLR);
    assign halted   = (state == S_HALT);
    assign t_state  = state;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed self-checking bench for sap_control_sequencer; expected control words are hand-written per T-state.
// Honours SEQ_COND_JUMP_EN when choosing the expected conditional-jump strobes.
module tb_sap_control_sequencer;

    logic       clk;
    logic       rst;
    logic       run;
    logic [3:0] ir_opcode;
    logic       flag_c;
    logic       flag_z;
    logic       pc_clr_n, cp, ep, lp, lm, ce, li, ei, la, ea, lb, su, eu, lo, halted;
    logic [2:0] t_state;

    int checkCount;
    int failCount;

    localparam logic [12:0] CP = 13'h1000;
    localparam logic [12:0] EP = 13'h0800;
    localparam logic [12:0] LP = 13'h0400;
    localparam logic [12:0] LM = 13'h0200;
    localparam logic [12:0] CE = 13'h0100;
    localparam logic [12:0] LI = 13'h0080;
    localparam logic [12:0] EI = 13'h0040;
    localparam logic [12:0] LA = 13'h0020;
    localparam logic [12:0] EA = 13'h0010;
    localparam logic [12:0] LB = 13'h0008;
    localparam logic [12:0] SU = 13'h0004;
    localparam logic [12:0] EU = 13'h0002;
    localparam logic [12:0] LO = 13'h0001;
    localparam logic [12:0] NONE = 13'h0000;

    sap_control_sequencer #(.OPW(4)) dut (
        .clk(clk), .rst(rst), .run(run), .ir_opcode(ir_opcode),
        .flag_c(flag_c), .flag_z(flag_z),
        .pc_clr_n(pc_clr_n), .cp(cp), .ep(ep), .lp(lp), .lm(lm), .ce(ce), .li(li),
        .ei(ei), .la(la), .ea(ea), .lb(lb), .su(su), .eu(eu), .lo(lo),
        .halted(halted), .t_state(t_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observed control word: {pc_clr_n, halted, t_state, 13 strobes}.
    function automatic logic [17:0] observed();
        return {pc_clr_n, halted, t_state, cp, ep, lp, lm, ce, li, ei, la, ea, lb, su, eu, lo};
    endfunction

    function automatic logic [17:0] expectWord(input logic [2:0] t, input logic [12:0] s,
                                               input logic clrn, input logic h);
        return {clrn, h, t, s};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] op, input logic c, input logic z);
        run       = r;
        ir_opcode = op;
        flag_c    = c;
        flag_z    = z;
    endtask

    // Advance one clock, then compare the word and the single-bus-driver rule at the negedge.
    task automatic step(input string tag, input logic [17:0] exp);
        @(negedge clk);
        checkOutput(tag, 32'(observed()), 32'(exp));
        checkOutput({tag, "_bus"}, 32'($countones({ep, ce, ei, ea, eu}) <= 1), 32'd1);
    endtask

    task automatic fetch(input logic [3:0] op);
        applyStimulus(1'b1, op, flag_c, flag_z);
        step("t2", expectWord(3'd2, CP, 1'b1, 1'b0));
        step("t3", expectWord(3'd3, CE | LI, 1'b1, 1'b0));
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("reset_clr", 32'(observed()), 32'(expectWord(3'd0, NONE, 1'b0, 1'b0)));

        // Leave CLR with run low: T1 is still entered, but frozen with no strobes.
        rst = 1'b0;
        step("t1_frozen", expectWord(3'd1, NONE, 1'b1, 1'b0));
        applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0);
        #1 checkOutput("t1", 32'(observed()), 32'(expectWord(3'd1, EP | LM, 1'b1, 1'b0)));

        // SUB
        fetch(4'b0010);
        step("sub_t4", expectWord(3'd4, EI | LM, 1'b1, 1'b0));
        step("sub_t5", expectWord(3'd5, CE | LB, 1'b1, 1'b0));
        step("sub_t6", expectWord(3'd6, SU | EU | LA, 1'b1, 1'b0));
        step("sub_t1", expectWord(3'd1, EP | LM, 1'b1, 1'b0));

        // ADD
        fetch(4'b0001);
        step("add_t4", expectWord(3'd4, EI | LM, 1'b1, 1'b0));
        step("add_t5", expectWord(3'd5, CE | LB, 1'b1, 1'b0));
        step("add_t6", expectWord(3'd6, EU | LA, 1'b1, 1'b0));
        step("add_t1", expectWord(3'd1, EP | LM, 1'b1, 1'b0));

        // LDA
        fetch(4'b0000);
        step("lda_t4", expectWord(3'd4, EI | LM, 1'b1, 1'b0));
        step("lda_t5", expectWord(3'd5, CE | LA, 1'b1, 1'b0));
        step("lda_t6", expectWord(3'd6, NONE, 1'b1, 1'b0));
        step("lda_t1", expectWord(3'd1, EP | LM, 1'b1, 1'b0));

        // JMP, OUT, NOP are one-state executes
        fetch(4'b0011);
        step("jmp_t4", expectWord(3'd4, EI | LP, 1'b1, 1'b0));
        step("jmp_t1", expectWord(3'd1, EP | LM, 1'b1, 1'b0));
        fetch(4'b1110);
        step("out_t4", expectWord(3'd4, EA | LO, 1'b1, 1'b0));
        step("out_t1", expectWord(3'd1, EP | LM, 1'b1, 1'b0));
        fetch(4'b0111);
        step("nop_t4", expectWord(3'd4, NONE, 1'b1, 1'b0));
        step("nop_t1", expectWord(3'd1, EP | LM, 1'b1, 1'b0));

        // Freeze in T2 for 5 cycles, then exactly one cp pulse on resume
        step("frz_t2", expectWord(3'd2, CP, 1'b1, 1'b0));
        applyStimulus(1'b0, 4'b0101, 1'b0, 1'b0);
        #1 checkOutput("frz_hold0", 32'(observed()), 32'(expectWord(3'd2, NONE, 1'b1, 1'b0)));
        for (int i = 0; i < 5; i++)
            step("frz_hold", expectWord(3'd2, NONE, 1'b1, 1'b0));
        applyStimulus(1'b1, 4'b0101, 1'b0, 1'b0);
        #1 checkOutput("frz_resume", 32'(observed()), 32'(expectWord(3'd2, CP, 1'b1, 1'b0)));
        step("frz_t3", expectWord(3'd3, CE | LI, 1'b1, 1'b0));

        // JZ with flag_z low, then high
        step("jz0_t4", expectWord(3'd4, NONE, 1'b1, 1'b0));
        step("jz0_t1", expectWord(3'd1, EP | LM, 1'b1, 1'b0));
        applyStimulus(1'b1, 4'b0101, 1'b0, 1'b1);
        fetch(4'b0101);
`ifdef SEQ_COND_JUMP_EN
        step("jz1_t4", expectWord(3'd4, EI | LP, 1'b1, 1'b0));
`else
        step("jz1_t4", expectWord(3'd4, NONE, 1'b1, 1'b0));
`endif
        step("jz1_t1", expectWord(3'd1, EP | LM, 1'b1, 1'b0));
        applyStimulus(1'b1, 4'b0100, 1'b1, 1'b0);
        fetch(4'b0100);
`ifdef SEQ_COND_JUMP_EN
        step("jc1_t4", expectWord(3'd4, EI | LP, 1'b1, 1'b0));
`else
        step("jc1_t4", expectWord(3'd4, NONE, 1'b1, 1'b0));
`endif
        step("jc1_t1", expectWord(3'd1, EP | LM, 1'b1, 1'b0));

        // HLT is sticky regardless of run
        applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
        fetch(4'b1111);
        step("hlt_t4", expectWord(3'd4, NONE, 1'b1, 1'b0));
        for (int i = 0; i < 20; i++) begin
            step("halt", expectWord(3'd7, NONE, 1'b1, 1'b1));
            applyStimulus(~run, 4'b0011, 1'b1, 1'b1);
        end
        #2 rst = 1'b1;
        #1 checkOutput("halt_rst", 32'(observed()), 32'(expectWord(3'd0, NONE, 1'b0, 1'b0)));

        // Abort a SUB in T5 with an asynchronous reset
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0);
        step("ab_t1", expectWord(3'd1, EP | LM, 1'b1, 1'b0));
        fetch(4'b0010);
        step("ab_t4", expectWord(3'd4, EI | LM, 1'b1, 1'b0));
        step("ab_t5", expectWord(3'd5, CE | LB, 1'b1, 1'b0));
        #2 rst = 1'b1;
        #1 checkOutput("abort_rst", 32'(observed()), 32'(expectWord(3'd0, NONE, 1'b0, 1'b0)));
        @(negedge clk);
        rst = 1'b0;
        step("ab_restart", expectWord(3'd1, EP | LM, 1'b1, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
